// File: rtl/result_argmax.sv
// result_argmax: scans a signed 32-bit result array over an Avalon-MM master and posts
// the maximum value and the index of its first occurrence. Macro RESULT_ARGMAX_IRQ_EN adds the done interrupt.
module result_argmax (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        slave_chipselect,
    input  logic        slave_read,
    input  logic        slave_write,
    input  logic [1:0]  slave_address,
    input  logic [31:0] slave_writedata,
    output logic [31:0] slave_readdata,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_waitrequest,
    output logic        irq
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        READ,
        CMP,
        DONE
    } state_t;

    localparam logic [31:0] MIN_VAL = 32'h8000_0000;

    state_t      state_q, state_d;
    logic        go_q, go_d;
    logic [10:0] count_q, count_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic [29:0] base_q, base_d;
    logic [31:0] maxval_q, maxval_d;
    logic [10:0] maxidx_q, maxidx_d;
    logic [10:0] idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] readdata_q, readdata_d;
    logic        master_read_q, master_read_d;
    logic [31:0] master_address_q, master_address_d;
    logic        irq_q, irq_d;

    logic        slave_rd;
    logic        slave_wr;
    logic        busy;
    logic [31:0] base_addr;
    logic [31:0] ctrl_word;
    logic        unused_wdata;

    // A simultaneous read and write is resolved in favour of the read.
    assign slave_rd     = slave_chipselect & slave_read;
    assign slave_wr     = slave_chipselect & slave_write & ~slave_read;
    assign busy         = (state_q != IDLE);
    assign base_addr    = {base_q, 2'b00};
    assign ctrl_word    = {done_q, irq_en_q, 18'd0, count_q, go_q};
    assign unused_wdata = ^slave_writedata[30:12];

    always_comb begin
        state_d    = state_q;
        go_d       = go_q;
        count_d    = count_q;
        irq_en_d   = irq_en_q;
        done_d     = done_q;
        base_d     = base_q;
        maxval_d   = maxval_q;
        maxidx_d   = maxidx_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        readdata_d = readdata_q;

        if (slave_rd) begin
            case (slave_address)
                2'd0:    readdata_d = ctrl_word;
                2'd1:    readdata_d = base_addr;
                2'd2:    readdata_d = maxval_q;
                default: readdata_d = {21'd0, maxidx_q};
            endcase
        end

        if (slave_wr && !busy) begin
            if (slave_address == 2'd0) begin
                go_d    = slave_writedata[0];
                count_d = slave_writedata[11:1];
                done_d  = 1'b0;
`ifdef RESULT_ARGMAX_IRQ_EN
                irq_en_d = slave_writedata[30];
`endif
            end else if (slave_address == 2'd1) begin
                base_d = slave_writedata[31:2];
            end
        end

        case (state_q)
            IDLE: begin
                if (go_q) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                idx_d    = 11'd0;
                maxval_d = MIN_VAL;
                maxidx_d = 11'd0;
                state_d  = (count_q == 11'd0) ? DONE : READ;
            end
            READ: begin
                if (!master_waitrequest) begin
                    rdata_d = master_readdata;
                    state_d = CMP;
                end
            end
            CMP: begin
                // Strictly-greater keeps the lowest index on ties; element 0 always seeds the max.
                if (($signed(rdata_q) > $signed(maxval_q)) || (idx_q == 11'd0)) begin
                    maxval_d = rdata_q;
                    maxidx_d = idx_q;
                end
                idx_d   = idx_q + 11'd1;
                state_d = (idx_d == count_q) ? DONE : READ;
            end
            DONE: begin
                done_d  = 1'b1;
                go_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Master outputs are registered from the next state so they line up with READ.
        master_read_d    = (state_d == READ);
        master_address_d = master_read_d ? (base_addr + {19'd0, idx_d, 2'b00}) : 32'd0;

`ifdef RESULT_ARGMAX_IRQ_EN
        irq_d = done_d & irq_en_d;
`else
        irq_en_d = 1'b0;
        irq_d    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= IDLE;
            go_q             <= 1'b0;
            count_q          <= 11'd0;
            irq_en_q         <= 1'b0;
            done_q           <= 1'b0;
            base_q           <= 30'd0;
            maxval_q         <= MIN_VAL;
            maxidx_q         <= 11'd0;
            idx_q            <= 11'd0;
            rdata_q          <= 32'd0;
            readdata_q       <= 32'd0;
            master_read_q    <= 1'b0;
            master_address_q <= 32'd0;
            irq_q            <= 1'b0;
        end else begin
            state_q          <= state_d;
            go_q             <= go_d;
            count_q          <= count_d;
            irq_en_q         <= irq_en_d;
            done_q           <= done_d;
            base_q           <= base_d;
            maxval_q         <= maxval_d;
            maxidx_q         <= maxidx_d;
            idx_q            <= idx_d;
            rdata_q          <= rdata_d;
            readdata_q       <= readdata_d;
            master_read_q    <= master_read_d;
            master_address_q <= master_address_d;
            irq_q            <= irq_d;
        end
    end

    assign slave_readdata = readdata_q;
    assign master_read    = master_read_q;
    assign master_address = master_address_q;
    assign irq            = irq_q;

endmodule

// File: tb/tb_result_argmax.sv
// Testbench for result_argmax: table-driven scans against a small memory responder,
// plus hand-written busy, read/write collision, reset and interrupt sequences.
module tb_result_argmax;

    logic        clk;
    logic        reset_n;
    logic        slave_chipselect;
    logic        slave_read;
    logic        slave_write;
    logic [1:0]  slave_address;
    logic [31:0] slave_writedata;
    logic [31:0] slave_readdata;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata;
    logic        master_waitrequest;
    logic        irq;

    int checks = 0;
    int errors = 0;

`ifdef RESULT_ARGMAX_IRQ_EN
    localparam bit IrqBuilt = 1'b1;
`else
    localparam bit IrqBuilt = 1'b0;
`endif

    result_argmax dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .slave_chipselect   (slave_chipselect),
        .slave_read         (slave_read),
        .slave_write        (slave_write),
        .slave_address      (slave_address),
        .slave_writedata    (slave_writedata),
        .slave_readdata     (slave_readdata),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_readdata    (master_readdata),
        .master_waitrequest (master_waitrequest),
        .irq                (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory responder: eight words at mem_base, wait_cycles stall cycles per read.
    logic [31:0] mem_arr [8];
    logic [31:0] mem_base;
    logic [31:0] mem_off;
    int          wait_cycles;
    int          stall_cnt;

    always_comb begin
        mem_off = master_address - mem_base;
        if (mem_off[31:5] == 27'd0) begin
            master_readdata = mem_arr[mem_off[4:2]];
        end else begin
            master_readdata = 32'hDEAD_BEEF;
        end
    end

    assign master_waitrequest = master_read && (stall_cnt < wait_cycles);

    always @(posedge clk) begin
        if (master_read && master_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end else begin
            stall_cnt <= 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Bus monitor: logs accepted addresses and holds master_read/address steady across stalls.
    logic [31:0] accepts [$];
    int          read_cycles;
    logic        prev_stall;
    logic [31:0] prev_addr;

    initial begin
        prev_stall  = 1'b0;
        prev_addr   = 32'd0;
        read_cycles = 0;
        stall_cnt   = 0;
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (master_read) begin
                read_cycles++;
            end
            if (prev_stall) begin
                checkOutput("read_hold", {31'd0, master_read}, 32'd1);
                checkOutput("addr_hold", master_address, prev_addr);
            end
            if (master_read && !master_waitrequest) begin
                accepts.push_back(master_address);
            end
            prev_stall = master_read && master_waitrequest;
            prev_addr  = master_address;
        end else begin
            prev_stall = 1'b0;
        end
    end

    typedef struct {
        logic [31:0]       base;
        logic [10:0]       count;
        int                waits;
        logic [7:0][31:0]  mem;
        logic [31:0]       exp_max;
        logic [10:0]       exp_idx;
        int                exp_edge;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(input logic [31:0] base, input logic [10:0] count, input int waits,
                                input logic [31:0] m0, input logic [31:0] m1, input logic [31:0] m2,
                                input logic [31:0] m3, input logic [31:0] m4,
                                input logic [31:0] exp_max, input logic [10:0] exp_idx, input int exp_edge);
        vec_t v;
        v.base     = base;
        v.count    = count;
        v.waits    = waits;
        v.mem      = '0;
        v.mem[0]   = m0;
        v.mem[1]   = m1;
        v.mem[2]   = m2;
        v.mem[3]   = m3;
        v.mem[4]   = m4;
        v.exp_max  = exp_max;
        v.exp_idx  = exp_idx;
        v.exp_edge = exp_edge;
        return v;
    endfunction

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        @(negedge clk);
        slave_chipselect = 1'b1;
        slave_write      = 1'b1;
        slave_read       = 1'b0;
        slave_address    = addr;
        slave_writedata  = data;
        @(negedge clk);
        slave_chipselect = 1'b0;
        slave_write      = 1'b0;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        @(negedge clk);
        slave_chipselect = 1'b1;
        slave_read       = 1'b1;
        slave_write      = 1'b0;
        slave_address    = addr;
        @(negedge clk);
        data             = slave_readdata;
        slave_chipselect = 1'b0;
        slave_read       = 1'b0;
    endtask

    // Writes CTRL at edge E0, then reads CTRL every cycle; edge_n is the first n for
    // which the read sampled at edge En returns done=1 (-1 if the budget runs out).
    task automatic runScan(input logic [31:0] ctrl, input int budget, output int edge_n);
        edge_n = -1;
        @(negedge clk);
        slave_chipselect = 1'b1;
        slave_write      = 1'b1;
        slave_read       = 1'b0;
        slave_address    = 2'd0;
        slave_writedata  = ctrl;
        @(negedge clk);
        slave_write      = 1'b0;
        slave_read       = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(negedge clk);
            if (slave_readdata[31]) begin
                edge_n = n;
                break;
            end
        end
        slave_read       = 1'b0;
        slave_chipselect = 1'b0;
    endtask

    task automatic loadMem(input vec_t v);
        for (int k = 0; k < 8; k++) begin
            mem_arr[k] = v.mem[k];
        end
        mem_base    = v.base & 32'hFFFF_FFFC;
        wait_cycles = v.waits;
    endtask

    task automatic applyStimulus(input int i);
        vec_t        v;
        logic [31:0] eff_base;
        logic [31:0] got;
        int          edge_n;
        v        = vecs[i];
        eff_base = v.base & 32'hFFFF_FFFC;
        loadMem(v);
        busWrite(2'd1, v.base);
        accepts.delete();
        read_cycles = 0;
        runScan({20'd0, v.count, 1'b1}, 300, edge_n);
        checkOutput($sformatf("v%0d_done_edge", i), edge_n, v.exp_edge);
        checkOutput($sformatf("v%0d_accepts", i), accepts.size(), {21'd0, v.count});
        for (int j = 0; j < accepts.size() && j < int'(v.count); j++) begin
            checkOutput($sformatf("v%0d_addr%0d", i, j), accepts[j], eff_base + 32'(4 * j));
        end
        if (v.count == 11'd0) begin
            checkOutput($sformatf("v%0d_no_master_read", i), read_cycles, 32'd0);
        end
        busRead(2'd2, got);
        checkOutput($sformatf("v%0d_maxval", i), got, v.exp_max);
        busRead(2'd3, got);
        checkOutput($sformatf("v%0d_maxidx", i), got, {21'd0, v.exp_idx});
        busRead(2'd0, got);
        checkOutput($sformatf("v%0d_ctrl", i), got, {1'b1, 19'd0, v.count, 1'b0});
        busRead(2'd1, got);
        checkOutput($sformatf("v%0d_base", i), got, eff_base);
        checkOutput($sformatf("v%0d_irq", i), {31'd0, irq}, 32'd0);
    endtask

    initial begin
        logic [31:0] got;
        int          edge_n;
        bit          seen;

        vecs[0] = mk(32'h0000_1000, 11'd5, 0, 32'd5, 32'hFFFF_FFFD, 32'd9, 32'd9, 32'd2,
                     32'd9, 11'd2, 14);
        vecs[1] = mk(32'h0000_2000, 11'd3, 3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFF7, 32'd0, 32'd0,
                     32'hFFFF_FFFE, 11'd1, 19);
        vecs[2] = mk(32'h0000_1000, 11'd0, 0, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7,
                     32'h8000_0000, 11'd0, 4);
        vecs[3] = mk(32'h0000_3001, 11'd3, 0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0,
                     32'h8000_0000, 11'd0, 10);
        vecs[4] = mk(32'h0000_4000, 11'd3, 1, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd0, 32'd0,
                     32'h7FFF_FFFF, 11'd2, 13);
        vecs[5] = mk(32'hFFFF_FFF8, 11'd3, 0, 32'd1, 32'd4, 32'd3, 32'd0, 32'd0,
                     32'd4, 11'd1, 10);
        vecs[6] = mk(32'h0000_0500, 11'd1, 2, 32'hFFFF_FFFB, 32'd0, 32'd0, 32'd0, 32'd0,
                     32'hFFFF_FFFB, 11'd0, 8);

        reset_n          = 1'b0;
        slave_chipselect = 1'b0;
        slave_read       = 1'b0;
        slave_write      = 1'b0;
        slave_address    = 2'd0;
        slave_writedata  = 32'd0;
        mem_base         = 32'd0;
        wait_cycles      = 0;
        for (int k = 0; k < 8; k++) begin
            mem_arr[k] = 32'd0;
        end

        repeat (3) @(negedge clk);
        checkOutput("rst_master_read", {31'd0, master_read}, 32'd0);
        checkOutput("rst_master_addr", master_address, 32'd0);
        checkOutput("rst_readdata", slave_readdata, 32'd0);
        checkOutput("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        busRead(2'd0, got);
        checkOutput("rst_ctrl", got, 32'd0);
        busRead(2'd1, got);
        checkOutput("rst_base", got, 32'd0);
        busRead(2'd2, got);
        checkOutput("rst_maxval", got, 32'h8000_0000);
        busRead(2'd3, got);
        checkOutput("rst_maxidx", got, 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i);
        end

        // Busy protection: BASE and CTRL writes during a scan must be ignored.
        $display("[TB] busy protection sequence");
        loadMem(vecs[0]);
        busWrite(2'd1, 32'h0000_1000);
        accepts.delete();
        busWrite(2'd0, 32'h0000_000B);
        busWrite(2'd1, 32'h0000_2000);
        busWrite(2'd0, 32'h0000_0000);
        got = 32'd0;
        for (int t = 0; t < 60; t++) begin
            busRead(2'd0, got);
            if (got[31]) break;
        end
        checkOutput("busy_done", {31'd0, got[31]}, 32'd1);
        checkOutput("busy_ctrl", got, 32'h8000_000A);
        checkOutput("busy_accepts", accepts.size(), 32'd5);
        for (int j = 0; j < accepts.size() && j < 5; j++) begin
            checkOutput($sformatf("busy_addr%0d", j), accepts[j], 32'h0000_1000 + 32'(4 * j));
        end
        busRead(2'd1, got);
        checkOutput("busy_base", got, 32'h0000_1000);
        busRead(2'd2, got);
        checkOutput("busy_maxval", got, 32'd9);
        busRead(2'd3, got);
        checkOutput("busy_maxidx", got, 32'd2);

        // Read and write in the same cycle: the read is serviced, the write dropped.
        @(negedge clk);
        slave_chipselect = 1'b1;
        slave_read       = 1'b1;
        slave_write      = 1'b1;
        slave_address    = 2'd1;
        slave_writedata  = 32'h0000_7770;
        @(negedge clk);
        checkOutput("rw_collide_read", slave_readdata, 32'h0000_1000);
        slave_chipselect = 1'b0;
        slave_read       = 1'b0;
        slave_write      = 1'b0;
        busRead(2'd1, got);
        checkOutput("rw_collide_base", got, 32'h0000_1000);

        // Reset in the middle of a stalled read.
        $display("[TB] reset mid-scan sequence");
        loadMem(vecs[0]);
        wait_cycles = 3;
        busWrite(2'd0, 32'h0000_000B);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (master_read) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput("rstmid_reached_read", {31'd0, seen}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_master_read", {31'd0, master_read}, 32'd0);
        checkOutput("rstmid_master_addr", master_address, 32'd0);
        checkOutput("rstmid_readdata", slave_readdata, 32'd0);
        repeat (2) @(negedge clk);
        reset_n     = 1'b1;
        read_cycles = 0;
        accepts.delete();
        busRead(2'd0, got);
        checkOutput("rstmid_ctrl", got, 32'd0);
        busRead(2'd1, got);
        checkOutput("rstmid_base", got, 32'd0);
        busRead(2'd2, got);
        checkOutput("rstmid_maxval", got, 32'h8000_0000);
        busRead(2'd3, got);
        checkOutput("rstmid_maxidx", got, 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("rstmid_no_reads", read_cycles, 32'd0);

        // Interrupt: irq_en=1, count=1.
        $display("[TB] interrupt sequence");
        loadMem(vecs[6]);
        wait_cycles = 0;
        busWrite(2'd1, 32'h0000_0600);
        mem_base = 32'h0000_0600;
        runScan(32'h4000_0003, 100, edge_n);
        checkOutput("irq_done_edge", edge_n, 32'd6);
        checkOutput("irq_with_done", {31'd0, irq}, {31'd0, IrqBuilt});
        busRead(2'd0, got);
        checkOutput("irq_ctrl", got, {1'b1, IrqBuilt, 18'd0, 11'd1, 1'b0});
        checkOutput("irq_still_high", {31'd0, irq}, {31'd0, IrqBuilt});
        busWrite(2'd0, 32'h4000_0000);
        checkOutput("irq_cleared", {31'd0, irq}, 32'd0);
        busRead(2'd0, got);
        checkOutput("irq_ctrl_after_write", got, {1'b0, IrqBuilt, 30'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
